// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage in-order pipeline: forwarding selects, stall/flush
// control and saturating event counters, driven by a shadow copy of E/M/W state.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             RegWriteD,
   input  logic             LoadD,
   input  logic             PCSrcE,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [CNT_W-1:0] LdStallCnt,
   output logic [CNT_W-1:0] BrFlushCnt,
   output logic [CNT_W-1:0] MemStallCnt
);

   localparam logic [1:0] MODE_ADVANCE = 2'd0;
   localparam logic [1:0] MODE_LOADUSE = 2'd1;
   localparam logic [1:0] MODE_BRANCH  = 2'd2;
   localparam logic [1:0] MODE_FREEZE  = 2'd3;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   logic [4:0] Rs1E, Rs2E, RdE;
   logic       RegWriteE, LoadE;
   logic [4:0] RdM;
   logic       RegWriteM;
   logic [4:0] RdW;
   logic       RegWriteW;

   logic       memStall;
   logic       lwStall;
   logic [1:0] mode;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cur);
      if (&cur)
         return cur;
      return cur + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // The newer producer (M) wins over the older one (W); x0 never forwards.
   function automatic logic [1:0] fwdSel(
      input logic [4:0] srcReg,
      input logic [4:0] dstM,
      input logic       wenM,
      input logic [4:0] dstW,
      input logic       wenW
   );
      if ((srcReg != 5'd0) && wenM && (srcReg == dstM))
         return FWD_MEM;
      if ((srcReg != 5'd0) && wenW && (srcReg == dstW))
         return FWD_WB;
      return FWD_REG;
   endfunction

   assign memStall = !MemReadyM;
   assign lwStall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

   always_comb begin
      mode = MODE_ADVANCE;
      if (memStall)
         mode = MODE_FREEZE;
      else if (lwStall)
         mode = MODE_LOADUSE;
      else if (PCSrcE)
         mode = MODE_BRANCH;
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      case (mode)
         MODE_FREEZE: begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
         end
         MODE_LOADUSE: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
         MODE_BRANCH: begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end
         default: ;
      endcase
   end

   assign ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
   assign ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

   // Shadow pipeline D->E->M->W; FREEZE holds everything in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Rs1E      <= 5'd0;
         Rs2E      <= 5'd0;
         RdE       <= 5'd0;
         RegWriteE <= 1'b0;
         LoadE     <= 1'b0;
         RdM       <= 5'd0;
         RegWriteM <= 1'b0;
         RdW       <= 5'd0;
         RegWriteW <= 1'b0;
      end else begin
         case (mode)
            MODE_FREEZE: begin
            end
            MODE_LOADUSE, MODE_BRANCH: begin
               Rs1E      <= 5'd0;
               Rs2E      <= 5'd0;
               RdE       <= 5'd0;
               RegWriteE <= 1'b0;
               LoadE     <= 1'b0;
               RdM       <= RdE;
               RegWriteM <= RegWriteE;
               RdW       <= RdM;
               RegWriteW <= RegWriteM;
            end
            default: begin
               Rs1E      <= Rs1D;
               Rs2E      <= Rs2D;
               RdE       <= RdD;
               RegWriteE <= RegWriteD;
               LoadE     <= LoadD;
               RdM       <= RdE;
               RegWriteM <= RegWriteE;
               RdW       <= RdM;
               RegWriteW <= RegWriteM;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LdStallCnt  <= '0;
         BrFlushCnt  <= '0;
         MemStallCnt <= '0;
      end else begin
         if (mode == MODE_LOADUSE)
            LdStallCnt <= satInc(LdStallCnt);
         if (mode == MODE_BRANCH)
            BrFlushCnt <= satInc(BrFlushCnt);
         if (mode == MODE_FREEZE)
            MemStallCnt <= satInc(MemStallCnt);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory freeze,
// x0 handling, counter saturation (4-bit instance) and asynchronous reset.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic       RegWriteD, LoadD, PCSrcE, MemReadyM;

   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [15:0] LdStallCnt, BrFlushCnt, MemStallCnt;

   logic [1:0] ForwardAE4, ForwardBE4;
   logic       StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4;
   logic [3:0] LdStallCnt4, BrFlushCnt4, MemStallCnt4;

   logic [5:0] ctl;
   int nCmp = 0;
   int nErr = 0;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .LoadD(LoadD),
      .PCSrcE(PCSrcE), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE),
      .LdStallCnt(LdStallCnt), .BrFlushCnt(BrFlushCnt), .MemStallCnt(MemStallCnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .LoadD(LoadD),
      .PCSrcE(PCSrcE), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
      .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .StallM(StallM4),
      .FlushD(FlushD4), .FlushE(FlushE4),
      .LdStallCnt(LdStallCnt4), .BrFlushCnt(BrFlushCnt4), .MemStallCnt(MemStallCnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setD(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic ld);
      Rs1D = r1;
      Rs2D = r2;
      RdD = rd;
      RegWriteD = rw;
      LoadD = ld;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      PCSrcE = 1'b0;
      MemReadyM = 1'b1;
      setD(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

      // reset state and control during reset
      #2;
      chk("rst_fwdA", 32'(ForwardAE), 32'd0);
      chk("rst_fwdB", 32'(ForwardBE), 32'd0);
      chk("rst_ctl", 32'(ctl), 32'h00);
      chk("rst_ldcnt", 32'(LdStallCnt), 32'd0);
      PCSrcE = 1'b1;
      #1;
      chk("rst_ctl_branch", 32'(ctl), 32'h03);
      PCSrcE = 1'b0;
      MemReadyM = 1'b0;
      #1;
      chk("rst_ctl_mem", 32'(ctl), 32'h3C);
      PCSrcE = 1'b1;
      #0.5;
      chk("rst_ctl_mem_over_branch", 32'(ctl), 32'h3C);
      PCSrcE = 1'b0;
      MemReadyM = 1'b1;
      #2.5;
      chk("rst_memcnt_held", 32'(MemStallCnt), 32'd0);
      rst_n = 1'b1;

      // ALU chain, distance 1
      setD(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc();
      setD(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      cyc();
      chk("alu1_fwdA", 32'(ForwardAE), 32'd2);
      chk("alu1_fwdB", 32'(ForwardBE), 32'd2);
      chk("alu1_ctl", 32'(ctl), 32'h00);

      // ALU chain, distance 2
      setD(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc();
      setD(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      setD(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      cyc();
      chk("alu2_fwdA", 32'(ForwardAE), 32'd1);
      chk("alu2_fwdB", 32'(ForwardBE), 32'd1);

      // M and W both match: M wins
      setD(5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
      cyc();
      setD(5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
      cyc();
      setD(5'd9, 5'd9, 5'd10, 1'b1, 1'b0);
      cyc();
      chk("prio_fwdA", 32'(ForwardAE), 32'd2);
      chk("prio_fwdB", 32'(ForwardBE), 32'd2);

      // x0 never forwards or causes a load-use stall
      setD(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      cyc();
      setD(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      cyc();
      chk("x0_fwdA", 32'(ForwardAE), 32'd0);
      chk("x0_fwdB", 32'(ForwardBE), 32'd0);
      setD(5'd2, 5'd0, 5'd0, 1'b1, 1'b1);
      cyc();
      setD(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
      #1;
      chk("x0_load_ctl", 32'(ctl), 32'h00);

      // load-use
      setD(5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
      cyc();
      setD(5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
      #1;
      chk("lu_ctl", 32'(ctl), 32'h31);
      cyc();
      chk("lu_ctl_after", 32'(ctl), 32'h00);
      chk("lu_cnt", 32'(LdStallCnt), 32'd1);
      cyc();
      chk("lu_fwdA", 32'(ForwardAE), 32'd1);
      chk("lu_fwdB", 32'(ForwardBE), 32'd0);

      // branch
      setD(5'd1, 5'd2, 5'd11, 1'b1, 1'b0);
      cyc();
      setD(5'd11, 5'd11, 5'd12, 1'b1, 1'b0);
      PCSrcE = 1'b1;
      #1;
      chk("br_ctl", 32'(ctl), 32'h03);
      cyc();
      PCSrcE = 1'b0;
      chk("br_cnt", 32'(BrFlushCnt), 32'd1);
      chk("br_bubble_fwdA", 32'(ForwardAE), 32'd0);

      // load-use and branch together: branch only
      setD(5'd1, 5'd2, 5'd13, 1'b1, 1'b1);
      cyc();
      setD(5'd13, 5'd0, 5'd14, 1'b1, 1'b0);
      PCSrcE = 1'b1;
      #1;
      chk("lubr_ctl", 32'(ctl), 32'h03);
      cyc();
      PCSrcE = 1'b0;
      chk("lubr_ldcnt", 32'(LdStallCnt), 32'd1);
      chk("lubr_brcnt", 32'(BrFlushCnt), 32'd2);
      chk("lubr_bubble_fwdA", 32'(ForwardAE), 32'd0);

      // memory busy for 3 cycles with a forward pending
      setD(5'd1, 5'd2, 5'd15, 1'b1, 1'b0);
      cyc();
      setD(5'd15, 5'd2, 5'd16, 1'b1, 1'b0);
      cyc();
      setD(5'd16, 5'd16, 5'd17, 1'b1, 1'b0);
      MemReadyM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mem_ctl", 32'(ctl), 32'h3C);
         chk("mem_fwdA", 32'(ForwardAE), 32'd2);
         cyc();
      end
      MemReadyM = 1'b1;
      #1;
      chk("mem_cnt", 32'(MemStallCnt), 32'd3);
      chk("mem_fwdA_after", 32'(ForwardAE), 32'd2);
      chk("mem_fwdB_after", 32'(ForwardBE), 32'd0);
      chk("mem_ctl_after", 32'(ctl), 32'h00);

      // counter saturation on the 4-bit instance
      MemReadyM = 1'b0;
      for (int i = 0; i < 12; i++) cyc();
      chk("sat4_at_max", 32'(MemStallCnt4), 32'd15);
      chk("sat16_15", 32'(MemStallCnt), 32'd15);
      for (int i = 0; i < 4; i++) cyc();
      chk("sat4_held", 32'(MemStallCnt4), 32'd15);
      chk("sat16_19", 32'(MemStallCnt), 32'd19);
      chk("sat4_brcnt", 32'(BrFlushCnt4), 32'd2);
      MemReadyM = 1'b1;

      // asynchronous reset in the middle of a load-use stall
      setD(5'd1, 5'd2, 5'd19, 1'b1, 1'b0);
      cyc();
      setD(5'd19, 5'd0, 5'd20, 1'b1, 1'b1);
      cyc();
      setD(5'd20, 5'd20, 5'd21, 1'b1, 1'b0);
      #0.5;
      chk("arst_pre_ctl", 32'(ctl), 32'h31);
      chk("arst_pre_fwdA", 32'(ForwardAE), 32'd2);
      chk("arst_pre_ldcnt", 32'(LdStallCnt), 32'd1);
      #0.5;
      rst_n = 1'b0;
      #1;
      chk("arst_fwdA", 32'(ForwardAE), 32'd0);
      chk("arst_fwdB", 32'(ForwardBE), 32'd0);
      chk("arst_ldcnt", 32'(LdStallCnt), 32'd0);
      chk("arst_brcnt", 32'(BrFlushCnt), 32'd0);
      chk("arst_memcnt", 32'(MemStallCnt), 32'd0);
      chk("arst_ctl", 32'(ctl), 32'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ctl", 32'(ctl), 32'h00);
      cyc();
      chk("post_rst_fwdA", 32'(ForwardAE), 32'd0);
      chk("post_rst_ldcnt", 32'(LdStallCnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
